// File: rtl/ddr2_write_arbiter.sv
// Two-master arbiter in front of the DDR2 address/write-data FIFOs.
// Round-robin grants; a burst (one address + BEATS_PER_BURST beats) is never split between masters.
module ddr2_write_arbiter #(
  parameter int BEATS_PER_BURST  = 2,
  parameter int BURSTS_PER_GRANT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic [30:0]  p0_af_addr_din,
  input  logic         p0_af_wr_en,
  input  logic [127:0] p0_wdf_din,
  input  logic [15:0]  p0_wdf_mask_din,
  input  logic         p0_wdf_wr_en,
  output logic         p0_af_full,
  output logic         p0_wdf_full,
  output logic         p0_grant,
  input  logic         p1_req,
  input  logic [30:0]  p1_af_addr_din,
  input  logic         p1_af_wr_en,
  input  logic [127:0] p1_wdf_din,
  input  logic [15:0]  p1_wdf_mask_din,
  input  logic         p1_wdf_wr_en,
  output logic         p1_af_full,
  output logic         p1_wdf_full,
  output logic         p1_grant,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en,
  output logic         err_drop
);

  localparam int BW = $clog2(BEATS_PER_BURST) + 1;
  localparam int GW = $clog2(BURSTS_PER_GRANT) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic            gsel, gsel_nx;
  logic            pref, pref_nx;
  logic            af_taken, af_taken_nx;
  logic [BW-1:0]   beat_cnt, beat_cnt_nx;
  logic [GW-1:0]   burst_cnt, burst_cnt_nx;

  logic            granted, own_req, other_req, own_af_wr, own_wdf_wr;
  logic            own_af_full, own_wdf_full, af_acc, wdf_acc;
  logic            taken_n, complete, rel_count, rel_drop, release_now, drop;
  logic [BW-1:0]   beats_n;

  assign granted    = (state == GRANT);
  assign own_req    = gsel ? p1_req : p0_req;
  assign other_req  = gsel ? p0_req : p1_req;
  assign own_af_wr  = gsel ? p1_af_wr_en : p0_af_wr_en;
  assign own_wdf_wr = gsel ? p1_wdf_wr_en : p0_wdf_wr_en;

  assign own_af_full  = af_full | af_taken;
  assign own_wdf_full = wdf_full | (beat_cnt == BW'(BEATS_PER_BURST));

  // Only strobes that the owner could legally issue ever reach the controller.
  assign af_acc  = granted & own_af_wr  & ~own_af_full;
  assign wdf_acc = granted & own_wdf_wr & ~own_wdf_full;

  assign af_wr_en     = af_acc;
  assign wdf_wr_en    = wdf_acc;
  assign af_addr_din  = gsel ? p1_af_addr_din  : p0_af_addr_din;
  assign wdf_din      = gsel ? p1_wdf_din      : p0_wdf_din;
  assign wdf_mask_din = gsel ? p1_wdf_mask_din : p0_wdf_mask_din;

  assign p0_grant    = granted & ~gsel;
  assign p1_grant    = granted &  gsel;
  assign p0_af_full  = p0_grant ? own_af_full  : 1'b1;
  assign p0_wdf_full = p0_grant ? own_wdf_full : 1'b1;
  assign p1_af_full  = p1_grant ? own_af_full  : 1'b1;
  assign p1_wdf_full = p1_grant ? own_wdf_full : 1'b1;

  assign drop = (~p0_grant & (p0_af_wr_en | p0_wdf_wr_en))
              | (~p1_grant & (p1_af_wr_en | p1_wdf_wr_en))
              | (granted & ((own_af_wr & own_af_full) | (own_wdf_wr & own_wdf_full)));

  // Completion counts writes accepted in the current cycle.
  assign taken_n   = af_taken | af_acc;
  assign beats_n   = beat_cnt + BW'(wdf_acc);
  assign complete  = granted & taken_n & (beats_n == BW'(BEATS_PER_BURST));
  assign rel_count = complete & (burst_cnt == GW'(BURSTS_PER_GRANT - 1));
  // An idle owner may only walk away between bursts, never with a write in flight.
  assign rel_drop  = granted & ~own_req & ~af_taken & (beat_cnt == '0) & ~af_acc & ~wdf_acc;
  assign release_now = rel_count | rel_drop;

  always_comb begin
    state_nx     = state;
    gsel_nx      = gsel;
    pref_nx      = pref;
    af_taken_nx  = taken_n;
    beat_cnt_nx  = beats_n;
    burst_cnt_nx = burst_cnt;
    case (state)
      IDLE: begin
        af_taken_nx  = 1'b0;
        beat_cnt_nx  = '0;
        burst_cnt_nx = '0;
        if (p0_req | p1_req) begin
          state_nx = GRANT;
          gsel_nx  = (p0_req & p1_req) ? pref : p1_req;
        end
      end
      GRANT: begin
        if (complete) begin
          af_taken_nx  = 1'b0;
          beat_cnt_nx  = '0;
          burst_cnt_nx = burst_cnt + GW'(1);
        end
        if (release_now) begin
          pref_nx      = ~gsel;
          burst_cnt_nx = '0;
          if (other_req)     gsel_nx  = ~gsel;
          else if (!own_req) state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gsel      <= 1'b0;
      pref      <= 1'b0;
      af_taken  <= 1'b0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      err_drop  <= 1'b0;
    end else begin
      state     <= state_nx;
      gsel      <= gsel_nx;
      pref      <= pref_nx;
      af_taken  <= af_taken_nx;
      beat_cnt  <= beat_cnt_nx;
      burst_cnt <= burst_cnt_nx;
      err_drop  <= err_drop | drop;
    end
  end

endmodule

// File: tb/tb_ddr2_write_arbiter.sv
// Bench for ddr2_write_arbiter: directed scenarios plus randomized two-master streams
// checked against a round-robin burst-order model.
module tb_ddr2_write_arbiter;
  localparam int BEATS = 2;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req, af_we, wdf_we;
  logic [30:0] addr_in [2];
  logic [127:0] din [2];
  logic [15:0] mask_in [2];
  logic af_full, wdf_full;
  logic sel;
  int checks = 0;
  int errors = 0;

  wire [1:0]   w_af_full [2];
  wire [1:0]   w_wdf_full [2];
  wire [1:0]   w_grant [2];
  wire [30:0]  w_addr [2];
  wire         w_af_we [2];
  wire [127:0] w_data [2];
  wire [15:0]  w_mask [2];
  wire         w_wdf_we [2];
  wire         w_err [2];

  always #5 clk = ~clk;

  // Instance 0 re-arbitrates after every burst, instance 1 after every two.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    ddr2_write_arbiter #(.BEATS_PER_BURST(BEATS), .BURSTS_PER_GRANT(k + 1)) dut (
      .clk(clk), .rst(rst),
      .p0_req(req[0]), .p0_af_addr_din(addr_in[0]), .p0_af_wr_en(af_we[0]),
      .p0_wdf_din(din[0]), .p0_wdf_mask_din(mask_in[0]), .p0_wdf_wr_en(wdf_we[0]),
      .p0_af_full(w_af_full[k][0]), .p0_wdf_full(w_wdf_full[k][0]), .p0_grant(w_grant[k][0]),
      .p1_req(req[1]), .p1_af_addr_din(addr_in[1]), .p1_af_wr_en(af_we[1]),
      .p1_wdf_din(din[1]), .p1_wdf_mask_din(mask_in[1]), .p1_wdf_wr_en(wdf_we[1]),
      .p1_af_full(w_af_full[k][1]), .p1_wdf_full(w_wdf_full[k][1]), .p1_grant(w_grant[k][1]),
      .af_full(af_full), .wdf_full(wdf_full),
      .af_addr_din(w_addr[k]), .af_wr_en(w_af_we[k]),
      .wdf_din(w_data[k]), .wdf_mask_din(w_mask[k]), .wdf_wr_en(w_wdf_we[k]),
      .err_drop(w_err[k])
    );
  end

  wire [1:0]   vaf    = w_af_full[sel];
  wire [1:0]   vwdf   = w_wdf_full[sel];
  wire [1:0]   grant  = w_grant[sel];
  wire [30:0]  oaddr  = w_addr[sel];
  wire         oafwe  = w_af_we[sel];
  wire [127:0] odata  = w_data[sel];
  wire [15:0]  omask  = w_mask[sel];
  wire         owdfwe = w_wdf_we[sel];
  wire         oerr   = w_err[sel];

  task automatic do_reset();
    rst = 1'b1; req = '0; af_we = '0; wdf_we = '0; af_full = 1'b0; wdf_full = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1; req = '0; af_we = '0; wdf_we = '0; af_full = 1'b0; wdf_full = 1'b0;
    addr_in[0] = 31'h0123_4567; addr_in[1] = 31'h7654_3210;
    din[0] = {4{32'hAAAA_5555}}; din[1] = {4{32'h1234_ABCD}};
    mask_in[0] = 16'hF00F; mask_in[1] = 16'h0FF0;
    #3;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if ({oafwe, owdfwe} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {oafwe, owdfwe}); end
    checks++; if ({vaf, vwdf} !== 4'b1111) begin errors++; $display("FAIL reset_fulls got %b want 1111", {vaf, vwdf}); end
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", oerr); end
    checks++; if ({oaddr, odata, omask} !== {addr_in[0], din[0], mask_in[0]})
      begin errors++; $display("FAIL reset_mux got %h want %h", odata, din[0]); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_burst();
    logic [30:0] a; logic [127:0] d0, d1;
    sel = 1'b0; do_reset();
    a = 31'($urandom); d0 = {$urandom, $urandom, $urandom, $urandom}; d1 = {$urandom, $urandom, $urandom, $urandom};
    req[0] = 1'b1;
    #1; checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_c1_grant got %b want 00", grant); end
    @(negedge clk); #1;
    checks++; if ({grant, vaf[0], vwdf[0]} !== 4'b0100) begin errors++; $display("FAIL single_c2_state got %b want 0100", {grant, vaf[0], vwdf[0]}); end
    af_we[0] = 1'b1; addr_in[0] = a; wdf_we[0] = 1'b1; din[0] = d0; mask_in[0] = d0[15:0];
    #1; checks++;
    if ({oafwe, owdfwe, oaddr, odata, omask} !== {2'b11, a, d0, d0[15:0]})
      begin errors++; $display("FAIL single_c2_fwd got %b %h %h want 11 %h %h", {oafwe, owdfwe}, oaddr, odata, a, d0); end
    @(negedge clk); af_we[0] = 1'b0; #1;
    checks++; if ({grant, vaf[0], vwdf[0]} !== 4'b0110) begin errors++; $display("FAIL single_c3_state got %b want 0110", {grant, vaf[0], vwdf[0]}); end
    din[0] = d1; mask_in[0] = d1[15:0]; req[0] = 1'b0;
    #1; checks++;
    if ({oafwe, owdfwe, odata} !== {2'b01, d1}) begin errors++; $display("FAIL single_c3_fwd got %b %h want 01 %h", {oafwe, owdfwe}, odata, d1); end
    @(negedge clk); wdf_we[0] = 1'b0; #1;
    checks++; if ({grant, vaf, vwdf, oerr} !== 7'b0011110) begin errors++; $display("FAIL single_c4_idle got %b want 0011110", {grant, vaf, vwdf, oerr}); end
  endtask

  task automatic test_nonowner_drop();
    sel = 1'b0; do_reset();
    req[0] = 1'b1;
    @(negedge clk); #1;
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL drop_pre_err got %b want 0", oerr); end
    wdf_we[1] = 1'b1; din[1] = {4{32'hDEAD_BEEF}};
    #1; checks++;
    if ({owdfwe, vwdf[1], grant} !== 4'b0101) begin errors++; $display("FAIL drop_blocked got %b want 0101", {owdfwe, vwdf[1], grant}); end
    @(negedge clk); wdf_we[1] = 1'b0; #1;
    checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL drop_err_set got %b want 1", oerr); end
    repeat (3) @(negedge clk);
    #1; checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL drop_err_sticky got %b want 1", oerr); end
  endtask

  task automatic test_wdf_stall();
    logic [127:0] d1;
    sel = 1'b0; do_reset();
    d1 = {$urandom, $urandom, $urandom, $urandom};
    req[0] = 1'b1;
    @(negedge clk);
    af_we[0] = 1'b1; wdf_we[0] = 1'b1; addr_in[0] = 31'($urandom); din[0] = ~d1;
    @(negedge clk); af_we[0] = 1'b0; wdf_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      wdf_we[0] = (i == 2);
      #1; checks++;
      if ({vwdf[0], owdfwe, grant} !== 4'b1001) begin errors++; $display("FAIL stall_c%0d got %b want 1001", i, {vwdf[0], owdfwe, grant}); end
    end
    @(negedge clk); wdf_we[0] = 1'b0; wdf_full = 1'b0; #1;
    checks++; if ({vwdf[0], oerr} !== 2'b01) begin errors++; $display("FAIL stall_release got %b want 01", {vwdf[0], oerr}); end
    wdf_we[0] = 1'b1; din[0] = d1; req[0] = 1'b0;
    #1; checks++; if ({owdfwe, odata} !== {1'b1, d1}) begin errors++; $display("FAIL stall_beat1 got %b %h want 1 %h", owdfwe, odata, d1); end
    @(negedge clk); wdf_we[0] = 1'b0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL stall_end_grant got %b want 00", grant); end
  endtask

  task automatic test_async_reset();
    sel = 1'b0; do_reset();
    req[0] = 1'b1;
    @(negedge clk);
    af_we[0] = 1'b1; wdf_we[0] = 1'b1; af_we[1] = 1'b1;
    @(negedge clk); af_we = '0; wdf_we[0] = 1'b1; #1;
    checks++; if ({oerr, vaf[0], owdfwe} !== 3'b111) begin errors++; $display("FAIL arst_pre got %b want 111", {oerr, vaf[0], owdfwe}); end
    #1; rst = 1'b1; #1;
    checks++;
    if ({grant, oafwe, owdfwe, vaf, vwdf, oerr} !== 9'b000011110)
      begin errors++; $display("FAIL arst_immediate got %b want 000011110", {grant, oafwe, owdfwe, vaf, vwdf, oerr}); end
    @(negedge clk); rst = 1'b0; wdf_we[0] = 1'b0; #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arst_released got %b want 00", grant); end
    @(negedge clk); #1;
    checks++; if ({grant, vaf[0], vwdf[0]} !== 4'b0100) begin errors++; $display("FAIL arst_regrant got %b want 0100", {grant, vaf[0], vwdf[0]}); end
  endtask

  // Both masters raise req together; DDR2 must see whole bursts in round-robin order
  // with BURSTS_PER_GRANT = k+1 bursts per turn.
  task automatic test_stream(input logic k, input int n0, input int n1, input bit stall);
    logic [30:0] a [2][8];
    logic [127:0] d [2][8][BEATS];
    logic [30:0] qa [$];
    logic [127:0] qd [$];
    int n [2]; int rem [2]; int nb [2]; int bi [2]; int bs [2]; logic as_ [2];
    int cur, take, cyc;
    sel = k; do_reset();
    n[0] = n0; n[1] = n1;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 8; b++) begin
        a[p][b] = 31'($urandom);
        for (int j = 0; j < BEATS; j++) d[p][b][j] = {$urandom, $urandom, $urandom, $urandom};
      end
    rem[0] = n0; rem[1] = n1; nb[0] = 0; nb[1] = 0; cur = 0;
    while (rem[0] + rem[1] > 0) begin
      if (rem[cur] == 0) cur = 1 - cur;
      take = (rem[cur] < int'(k) + 1) ? rem[cur] : int'(k) + 1;
      for (int t = 0; t < take; t++) begin
        qa.push_back(a[cur][nb[cur]]);
        for (int j = 0; j < BEATS; j++) qd.push_back(d[cur][nb[cur]][j]);
        nb[cur]++; rem[cur]--;
      end
      if (rem[1 - cur] > 0) cur = 1 - cur;
    end
    for (int p = 0; p < 2; p++) begin bi[p] = 0; bs[p] = 0; as_[p] = 1'b0; end
    cyc = 0;
    while ((bi[0] < n[0] || bi[1] < n[1]) && cyc < LIMIT) begin
      @(negedge clk);
      af_full  = stall && ($urandom_range(0, 3) == 0);
      wdf_full = stall && ($urandom_range(0, 3) == 0);
      #1;
      for (int p = 0; p < 2; p++) begin
        af_we[p] = 1'b0; wdf_we[p] = 1'b0;
        if (bi[p] < n[p]) begin
          if (!as_[p] && !vaf[p] && $urandom_range(0, 3) != 0) begin
            af_we[p] = 1'b1; addr_in[p] = a[p][bi[p]]; as_[p] = 1'b1;
          end
          if (as_[p] && bs[p] < BEATS && !vwdf[p] && $urandom_range(0, 3) != 0) begin
            wdf_we[p] = 1'b1; din[p] = d[p][bi[p]][bs[p]]; mask_in[p] = din[p][127:112]; bs[p]++;
          end
          if (as_[p] && bs[p] == BEATS) begin bi[p]++; as_[p] = 1'b0; bs[p] = 0; end
        end
        req[p] = (bi[p] < n[p]);
      end
      #1;
      checks++; if (grant === 2'b11) begin errors++; $display("FAIL stream_dual_grant got %b want one-hot", grant); end
      if (oafwe) begin
        checks++;
        if (qa.size() == 0 || oaddr !== qa[0] || af_full)
          begin errors++; $display("FAIL stream_addr got %h want %h (full %b)", oaddr, (qa.size() != 0) ? qa[0] : 31'h0, af_full); end
        if (qa.size() != 0) qa.delete(0);
      end
      if (owdfwe) begin
        checks++;
        if (qd.size() == 0 || odata !== qd[0] || omask !== qd[0][127:112] || wdf_full)
          begin errors++; $display("FAIL stream_data got %h want %h (full %b)", odata, (qd.size() != 0) ? qd[0] : 128'h0, wdf_full); end
        if (qd.size() != 0) qd.delete(0);
      end
      cyc++;
    end
    @(negedge clk); af_we = '0; wdf_we = '0; req = '0; af_full = 1'b0; wdf_full = 1'b0; #1;
    checks++;
    if (cyc >= LIMIT || qa.size() != 0 || qd.size() != 0)
      begin errors++; $display("FAIL stream_complete got cyc %0d left %0d/%0d want all drained", cyc, qa.size(), qd.size()); end
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL stream_err got %b want 0", oerr); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_nonowner_drop();
    test_wdf_stall();
    test_async_reset();
    test_stream(1'b0, 3, 3, 1'b0);
    test_stream(1'b0, 3, 3, 1'b1);
    test_stream(1'b1, 2, 2, 1'b0);
    test_stream(1'b1, 3, 1, 1'b1);
    test_stream(1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 6), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
